path_history_spec_ctrl: RTL and testbench

- Sequences the 12-bit global path history used by the tournament predictor.
- Applies speculative shifts on each fetched prediction and checkpoints the pre-shift history per in-flight branch.
- On a mispredict, restores and repairs the history and squashes younger branches.
- Maintains a separate retired (architectural) history at commit. Sits between fetch/predict and branch resolution.

---
 rtl/path_history_spec_ctrl_pkg.sv | 25 ++
 rtl/path_history_spec_ctrl_if.sv | 40 ++++
 rtl/path_history_spec_ctrl_ph_ckpt_buffer.sv | 47 ++++
 rtl/path_history_spec_ctrl.sv | 111 +++++++++++
 tb/tb_path_history_spec_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/path_history_spec_ctrl_pkg.sv
// Shared definitions for the path history speculation controller.
//   HIST_W / DEPTH / TAG_W : history width, in-flight branch capacity, tag width
//   ph_t, tag_t, ptr_t     : history word, branch tag, wrap-bit pointer
//   ctrl_state_t           : RUN / RECOVER
//   shift_ph()             : history update, new bit into LSB, MSB dropped
package path_history_spec_ctrl_pkg;

   localparam int HIST_W = 12;
   localparam int DEPTH  = 8;
   localparam int TAG_W  = $clog2(DEPTH);

   typedef logic [HIST_W-1:0] ph_t;
   typedef logic [TAG_W-1:0]  tag_t;
   typedef logic [TAG_W:0]    ptr_t;   // extra MSB distinguishes full from empty

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } ctrl_state_t;

   function automatic ph_t shift_ph(input ph_t ph, input logic b);
      return {ph[HIST_W-2:0], b};
   endfunction

endpackage

// File: rtl/path_history_spec_ctrl_if.sv
// Bus between fetch/predict + branch resolution (master) and the path
// history controller (slave).
//   pred_*     : prediction handshake, pred_tag is the allocated branch tag
//   resolve_*  : branch resolution, mispredict carries the actual direction
//   commit_valid : retire oldest in-flight branch
//   spec_ph / retired_ph / inflight_cnt / full / empty : controller status
interface path_history_spec_ctrl_if
   import path_history_spec_ctrl_pkg::*;
();

   logic         pred_valid;
   logic         pred_taken;
   logic         pred_ready;
   tag_t         pred_tag;
   logic         resolve_valid;
   tag_t         resolve_tag;
   logic         resolve_mispredict;
   logic         resolve_taken;
   logic         commit_valid;
   ph_t          spec_ph;
   ph_t          retired_ph;
   ptr_t         inflight_cnt;
   logic         full;
   logic         empty;

   modport master (
      output pred_valid, pred_taken,
      output resolve_valid, resolve_tag, resolve_mispredict, resolve_taken,
      output commit_valid,
      input  pred_ready, pred_tag, spec_ph, retired_ph, inflight_cnt, full, empty
   );

   modport slave (
      input  pred_valid, pred_taken,
      input  resolve_valid, resolve_tag, resolve_mispredict, resolve_taken,
      input  commit_valid,
      output pred_ready, pred_tag, spec_ph, retired_ph, inflight_cnt, full, empty
   );

endinterface

// File: rtl/path_history_spec_ctrl_ph_ckpt_buffer.sv
// Per-branch checkpoint store: pre-shift history plus the branch outcome.
//   clock, reset        : clock, async active-high clear
//   wr_*                : allocate entry at tail (history + predicted outcome)
//   fix_*               : overwrite outcome of a mispredicted branch
//   head_idx/head_outcome : read port used at commit
//   rd_idx/rd_ph        : read port used for mispredict repair
module ph_ckpt_buffer
   import path_history_spec_ctrl_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic wr_en,
   input  tag_t wr_idx,
   input  ph_t  wr_ph,
   input  logic wr_outcome,
   input  logic fix_en,
   input  tag_t fix_idx,
   input  logic fix_outcome,
   input  tag_t head_idx,
   output logic head_outcome,
   input  tag_t rd_idx,
   output ph_t  rd_ph
);

   ph_t  [DEPTH-1:0] ckpt_q;
   logic [DEPTH-1:0] outc_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ckpt_q <= '0;
         outc_q <= '0;
      end else begin
         if (wr_en) begin
            ckpt_q[wr_idx] <= wr_ph;
            outc_q[wr_idx] <= wr_outcome;
         end
         // Fixup is listed last so it wins; the controller never
         // allocates in a mispredict cycle anyway.
         if (fix_en)
            outc_q[fix_idx] <= fix_outcome;
      end
   end

   assign head_outcome = outc_q[head_idx];
   assign rd_ph        = ckpt_q[rd_idx];

endmodule

// File: rtl/path_history_spec_ctrl.sv
// Global path history sequencer for the tournament predictor.
// Shifts the speculative history on every accepted prediction, checkpoints
// the pre-shift value per in-flight branch, repairs it on a mispredict
// (squashing younger branches) and keeps a retired history at commit.
//   clock, reset : clock, async active-high reset
//   bus          : slave side of path_history_spec_ctrl_if
module path_history_spec_ctrl
   import path_history_spec_ctrl_pkg::*;
(
   input  logic clock,
   input  logic reset,
   path_history_spec_ctrl_if.slave bus
);

   ptr_t        head_q, tail_q;
   ph_t         spec_q, ret_q;
   ctrl_state_t state_q, state_d;

   ptr_t cnt;
   logic full_w, empty_w;
   tag_t res_off;
   ptr_t res_ptr;
   logic tag_live, mispred, accept, commit;
   logic head_outcome, commit_outcome;
   ph_t  rd_ph;
   logic pred_ready_w;

   assign cnt     = tail_q - head_q;
   assign full_w  = (cnt == ptr_t'(DEPTH));
   assign empty_w = (cnt == '0);

   // Distance of the resolving tag from head, modulo DEPTH; it is live when
   // that distance is below the occupancy.
   assign res_off  = bus.resolve_tag - head_q[TAG_W-1:0];
   assign res_ptr  = head_q + {1'b0, res_off};
   assign tag_live = ({1'b0, res_off} < cnt);

   assign mispred = bus.resolve_valid && bus.resolve_mispredict && tag_live;
   assign accept  = bus.pred_valid && pred_ready_w;
   assign commit  = bus.commit_valid && !empty_w;

   // Committing the branch that is being repaired this cycle must see the
   // corrected direction, not the stale stored one.
   assign commit_outcome = (mispred && (res_off == '0)) ? bus.resolve_taken
                                                        : head_outcome;

   ph_ckpt_buffer u_buf (
      .clock        (clock),
      .reset        (reset),
      .wr_en        (accept),
      .wr_idx       (tail_q[TAG_W-1:0]),
      .wr_ph        (spec_q),
      .wr_outcome   (bus.pred_taken),
      .fix_en       (mispred),
      .fix_idx      (bus.resolve_tag),
      .fix_outcome  (bus.resolve_taken),
      .head_idx     (head_q[TAG_W-1:0]),
      .head_outcome (head_outcome),
      .rd_idx       (bus.resolve_tag),
      .rd_ph        (rd_ph)
   );

   // Datapath: histories and pointers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         spec_q <= '0;
         ret_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         if (mispred) begin
            spec_q <= shift_ph(rd_ph, bus.resolve_taken);
            tail_q <= res_ptr + ptr_t'(1);
         end else if (accept) begin
            spec_q <= shift_ph(spec_q, bus.pred_taken);
            tail_q <= tail_q + ptr_t'(1);
         end
         if (commit) begin
            ret_q  <= shift_ph(ret_q, commit_outcome);
            head_q <= head_q + ptr_t'(1);
         end
      end
   end

   // FSM: state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // FSM: next state. Any live mispredict (also one during RECOVER)
   // holds off predictions for the following cycle.
   always_comb begin
      state_d = RUN;
      if (mispred) state_d = RECOVER;
   end

   // FSM: outputs.
   always_comb begin
      pred_ready_w = (state_q == RUN) && !full_w && !mispred;
   end

   assign bus.pred_ready   = pred_ready_w;
   assign bus.pred_tag     = tail_q[TAG_W-1:0];
   assign bus.spec_ph      = spec_q;
   assign bus.retired_ph   = ret_q;
   assign bus.inflight_cnt = cnt;
   assign bus.full         = full_w;
   assign bus.empty        = empty_w;

endmodule

// File: tb/tb_path_history_spec_ctrl.sv
// Directed bench for path_history_spec_ctrl with hand-computed expectations.
module tb_path_history_spec_ctrl;
   import path_history_spec_ctrl_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   path_history_spec_ctrl_if bus ();

   path_history_spec_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.pred_valid         = 1'b0;
      bus.pred_taken         = 1'b0;
      bus.resolve_valid      = 1'b0;
      bus.resolve_tag        = '0;
      bus.resolve_mispredict = 1'b0;
      bus.resolve_taken      = 1'b0;
      bus.commit_valid       = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
   endtask

   task automatic accept(input logic b);
      bus.pred_valid = 1'b1;
      bus.pred_taken = b;
      tick();
      bus.pred_valid = 1'b0;
   endtask

   task automatic resolve(input int t, input logic mp, input logic tk);
      bus.resolve_valid      = 1'b1;
      bus.resolve_tag        = tag_t'(t);
      bus.resolve_mispredict = mp;
      bus.resolve_taken      = tk;
   endtask

   initial begin
      idle();

      // Reset values
      do_reset();
      chk("rst_spec", 32'(bus.spec_ph), 32'h000);
      chk("rst_ret", 32'(bus.retired_ph), 32'h000);
      chk("rst_cnt", 32'(bus.inflight_cnt), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_ready", 32'(bus.pred_ready), 1);

      // Fill with 8 taken predictions
      for (int i = 0; i < DEPTH; i++) begin
         bus.pred_valid = 1'b1;
         bus.pred_taken = 1'b1;
         #1;
         chk($sformatf("fill_tag%0d", i), 32'(bus.pred_tag), 32'(i));
         chk($sformatf("fill_rdy%0d", i), 32'(bus.pred_ready), 1);
         tick();
      end
      chk("fill_spec", 32'(bus.spec_ph), 32'h0FF);
      chk("fill_full", 32'(bus.full), 1);
      chk("fill_ready", 32'(bus.pred_ready), 0);
      tick();  // 9th pred_valid held against full
      bus.pred_valid = 1'b0;
      chk("fill_spec_hold", 32'(bus.spec_ph), 32'h0FF);
      chk("fill_cnt", 32'(bus.inflight_cnt), 8);

      // Mispredict repair: 1,0,1,1 then mispredict tag 1 taken
      do_reset();
      accept(1'b1); accept(1'b0); accept(1'b1); accept(1'b1);
      chk("mp_pre_spec", 32'(bus.spec_ph), 32'h00B);
      resolve(1, 1'b1, 1'b1);
      bus.pred_valid = 1'b1;   // collides with the mispredict
      bus.pred_taken = 1'b0;
      #1;
      chk("mp_coll_ready", 32'(bus.pred_ready), 0);
      tick();
      bus.resolve_valid = 1'b0;
      chk("mp_spec", 32'(bus.spec_ph), 32'h003);
      chk("mp_cnt", 32'(bus.inflight_cnt), 2);
      chk("mp_recover_ready", 32'(bus.pred_ready), 0);
      tick();
      chk("mp_dropped_spec", 32'(bus.spec_ph), 32'h003);
      chk("mp_run_ready", 32'(bus.pred_ready), 1);
      chk("mp_next_tag", 32'(bus.pred_tag), 2);
      tick();  // accept taken=0 with tag 2
      bus.pred_valid = 1'b0;
      chk("mp_after_spec", 32'(bus.spec_ph), 32'h006);
      chk("mp_after_cnt", 32'(bus.inflight_cnt), 3);

      // Mispredict tag 2 (ckpt 0x003) taken -> 0x007, then reset mid-RECOVER
      resolve(2, 1'b1, 1'b1);
      tick();
      idle();
      #1;
      chk("rec_spec", 32'(bus.spec_ph), 32'h007);
      chk("rec_ready", 32'(bus.pred_ready), 0);
      reset = 1'b1;
      #1;
      chk("arst_spec", 32'(bus.spec_ph), 32'h000);
      chk("arst_cnt", 32'(bus.inflight_cnt), 0);
      chk("arst_ready", 32'(bus.pred_ready), 1);
      chk("arst_empty", 32'(bus.empty), 1);

      // Commit: accept 1,1,0 then commit x3 (+1 on empty)
      do_reset();
      accept(1'b1); accept(1'b1); accept(1'b0);
      chk("cm_spec", 32'(bus.spec_ph), 32'h006);
      bus.commit_valid = 1'b1;
      tick(); chk("cm_ret1", 32'(bus.retired_ph), 32'h001);
      tick(); chk("cm_ret2", 32'(bus.retired_ph), 32'h003);
      tick(); chk("cm_ret3", 32'(bus.retired_ph), 32'h006);
      chk("cm_empty", 32'(bus.empty), 1);
      tick(); chk("cm_ret_empty", 32'(bus.retired_ph), 32'h006);
      bus.commit_valid = 1'b0;

      // Collision: mispredict of head + commit in the same cycle
      do_reset();
      accept(1'b0); accept(1'b0);
      resolve(0, 1'b1, 1'b1);
      bus.commit_valid = 1'b1;
      tick();
      idle();
      #1;
      chk("col_ret", 32'(bus.retired_ph), 32'h001);
      chk("col_spec", 32'(bus.spec_ph), 32'h001);
      chk("col_cnt", 32'(bus.inflight_cnt), 0);
      tick();
      // Non-live tag is ignored
      resolve(5, 1'b1, 1'b0);
      #1;
      chk("dead_ready", 32'(bus.pred_ready), 1);
      tick();
      idle();
      #1;
      chk("dead_spec", 32'(bus.spec_ph), 32'h001);
      chk("dead_ready_after", 32'(bus.pred_ready), 1);

      // Wrap: 8 pairs of accept 1 / accept 0, each followed by a commit
      do_reset();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("wrap_tag%0d", i), 32'(bus.pred_tag), 32'(i % DEPTH));
         accept((i % 2) == 0);
         bus.commit_valid = 1'b1;
         tick();
         bus.commit_valid = 1'b0;
      end
      chk("wrap_spec", 32'(bus.spec_ph), 32'hAAA);
      chk("wrap_ret", 32'(bus.retired_ph), 32'hAAA);
      chk("wrap_cnt", 32'(bus.inflight_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
